// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4 memory arbiter.
package axi_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational request-to-owner selection for axi_mem_arbiter.
// ARB_ROUND_ROBIN_EN switches read arbitration from fixed LSU priority to round-robin.
module axi_arb_pick
   import axi_mem_arbiter_pkg::*;
(
   input  logic   ifu_rd,
   input  logic   lsu_rd,
   input  logic   lsu_wr,
`ifdef ARB_ROUND_ROBIN_EN
   input  owner_e last_owner,
`endif
   output logic   req,
   output owner_e owner,
   output logic   write
);

   logic lsu_req;

   always_comb begin
      lsu_req = lsu_rd | lsu_wr;
      req     = ifu_rd | lsu_req;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie the master that did not own the port last time goes first.
      if (ifu_rd && lsu_req) begin
         owner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
      end else begin
         owner = lsu_req ? OWN_LSU : OWN_IFU;
      end
`else
      owner = lsu_req ? OWN_LSU : OWN_IFU;
`endif
      write = (owner == OWN_LSU) && !lsu_rd && lsu_wr;
   end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 transaction arbiter.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; default is fixed LSU priority.
module axi_mem_arbiter
   import axi_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [ID_W-1:0]     m0_arid,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rlast,
   output logic [ID_W-1:0]     m0_rid,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [ID_W-1:0]     m1_arid,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rlast,
   output logic [ID_W-1:0]     m1_rid,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic [1:0]          m1_bresp,
   output logic [ID_W-1:0]     m1_bid,
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [ID_W-1:0]     s_arid,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   input  logic                s_rvalid,
   output logic                s_rready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rlast,
   input  logic [ID_W-1:0]     s_rid,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [ID_W-1:0]     s_awid,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   input  logic                s_bvalid,
   output logic                s_bready,
   input  logic [1:0]          s_bresp,
   input  logic [ID_W-1:0]     s_bid,
   output logic [1:0]          grant
);

   state_e state;
   owner_e owner;
   owner_e pick_owner;
   logic   pick_req;
   logic   pick_write;
   logic   rd_ifu;
   logic   rd_lsu;
   logic   wr_lsu;
`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_owner;
`endif

   axi_arb_pick u_pick (
      .ifu_rd     (m0_arvalid),
      .lsu_rd     (m1_arvalid),
      .lsu_wr     (m1_awvalid),
`ifdef ARB_ROUND_ROBIN_EN
      .last_owner (last_owner),
`endif
      .req        (pick_req),
      .owner      (pick_owner),
      .write      (pick_write)
   );

   // A transaction ends on the final R beat or the B handshake; IDLE is the bubble between owners.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= OWN_IFU;
         grant      <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner <= OWN_LSU;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_req) begin
                  state      <= pick_write ? WR : RD;
                  owner      <= pick_owner;
                  grant      <= (pick_owner == OWN_LSU) ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                  last_owner <= pick_owner;
`endif
               end
            end
            RD: begin
               if (s_rvalid && s_rready && s_rlast) begin
                  state <= IDLE;
                  grant <= 2'b00;
               end
            end
            WR: begin
               if (s_bvalid && s_bready) begin
                  state <= IDLE;
                  grant <= 2'b00;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

   assign rd_ifu = (state == RD) && (owner == OWN_IFU);
   assign rd_lsu = (state == RD) && (owner == OWN_LSU);
   assign wr_lsu = (state == WR);

   always_comb begin
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = RESP_OKAY;
      m0_rlast   = 1'b0;
      m0_rid     = '0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = RESP_OKAY;
      m1_rlast   = 1'b0;
      m1_rid     = '0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = RESP_OKAY;
      m1_bid     = '0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_arsize   = '0;
      s_arburst  = BURST_FIXED;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awid     = '0;
      s_awlen    = '0;
      s_awsize   = '0;
      s_awburst  = BURST_FIXED;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      if (rd_ifu) begin
         s_arvalid  = m0_arvalid;
         s_araddr   = m0_araddr;
         s_arid     = m0_arid;
         s_arlen    = m0_arlen;
         s_arsize   = m0_arsize;
         s_arburst  = m0_arburst;
         m0_arready = s_arready;
         m0_rvalid  = s_rvalid;
         m0_rdata   = s_rdata;
         m0_rresp   = s_rresp;
         m0_rlast   = s_rlast;
         m0_rid     = s_rid;
         s_rready   = m0_rready;
      end
      if (rd_lsu) begin
         s_arvalid  = m1_arvalid;
         s_araddr   = m1_araddr;
         s_arid     = m1_arid;
         s_arlen    = m1_arlen;
         s_arsize   = m1_arsize;
         s_arburst  = m1_arburst;
         m1_arready = s_arready;
         m1_rvalid  = s_rvalid;
         m1_rdata   = s_rdata;
         m1_rresp   = s_rresp;
         m1_rlast   = s_rlast;
         m1_rid     = s_rid;
         s_rready   = m1_rready;
      end
      if (wr_lsu) begin
         s_awvalid  = m1_awvalid;
         s_awaddr   = m1_awaddr;
         s_awid     = m1_awid;
         s_awlen    = m1_awlen;
         s_awsize   = m1_awsize;
         s_awburst  = m1_awburst;
         m1_awready = s_awready;
         s_wvalid   = m1_wvalid;
         s_wdata    = m1_wdata;
         s_wstrb    = m1_wstrb;
         s_wlast    = m1_wlast;
         m1_wready  = s_wready;
         m1_bvalid  = s_bvalid;
         m1_bresp   = s_bresp;
         m1_bid     = s_bid;
         s_bready   = m1_bready;
      end
   end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: directed scenarios plus randomized arbitration rounds.
module tb_axi_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clock, reset;
   logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [AW-1:0] m0_araddr;
   logic [IW-1:0] m0_arid, m0_rid;
   logic [7:0] m0_arlen;
   logic [2:0] m0_arsize;
   logic [1:0] m0_arburst, m0_rresp;
   logic [DW-1:0] m0_rdata;
   logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [AW-1:0] m1_araddr, m1_awaddr;
   logic [IW-1:0] m1_arid, m1_rid, m1_awid, m1_bid;
   logic [7:0] m1_arlen, m1_awlen;
   logic [2:0] m1_arsize, m1_awsize;
   logic [1:0] m1_arburst, m1_rresp, m1_awburst, m1_bresp;
   logic [DW-1:0] m1_rdata, m1_wdata;
   logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
   logic [DW/8-1:0] m1_wstrb;
   logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [AW-1:0] s_araddr, s_awaddr;
   logic [IW-1:0] s_arid, s_rid, s_awid, s_bid;
   logic [7:0] s_arlen, s_awlen;
   logic [2:0] s_arsize, s_awsize;
   logic [1:0] s_arburst, s_rresp, s_awburst, s_bresp;
   logic [DW-1:0] s_rdata, s_wdata;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic [DW/8-1:0] s_wstrb;
   logic [1:0] grant;

   int checks;
   int failures;
   int model_last;   // 0 = IFU, 1 = LSU owned the port last

   axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
      .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
      .m1_bid(m1_bid),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rid(s_rid),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
      .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_bid(s_bid), .grant(grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic init_inputs();
      m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2;
      m0_arburst = 2'b01; m0_rready = 1;
      m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2;
      m1_arburst = 2'b01; m1_rready = 1;
      m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2;
      m1_awburst = 2'b01; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0;
      m1_bready = 1;
      s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
   endtask

   // Next owner from the arbitration rules: 0 = IFU read, 1 = LSU read, 2 = LSU write.
   function automatic int pick_model(input bit ar0, input bit ar1, input bit aw1);
      bit lsu;
      lsu = ar1 | aw1;
      if (lsu && (!ar0 || !RR || model_last == 0)) return ar1 ? 1 : 2;
      return 0;
   endfunction

   // Entry: arbiter is in IDLE this cycle with the owner's request asserted.
   task automatic serve_read(input int who, input int rlat, input bit fix_d,
                             input logic [DW-1:0] fdata, input int fresp, input bit mid_lsu);
      int lat;
      int len;
      logic [DW-1:0] d;
      logic [1:0] rsp, eg;
      logic [AW-1:0] ea;
      logic [IW-1:0] eid;
      logic [7:0] elen;
      ea = (who != 0) ? m1_araddr : m0_araddr;
      eid = (who != 0) ? m1_arid : m0_arid;
      elen = (who != 0) ? m1_arlen : m0_arlen;
      len = int'(elen);
      eg = (who != 0) ? 2'b10 : 2'b01;
      tick(); #1;
      checks++;
      if (grant !== eg) begin
         failures++; $display("FAIL rd_grant: grant=%b expected=%b", grant, eg);
      end
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== ea || s_arid !== eid || s_arlen !== elen
          || s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
         failures++;
         $display("FAIL rd_ar_fwd: arvalid=%b araddr=%h arid=%h arlen=%0d awvalid=%b expected addr=%h id=%h len=%0d",
                  s_arvalid, s_araddr, s_arid, s_arlen, s_awvalid, ea, eid, elen);
      end
      lat = $urandom_range(0, 2);
      repeat (lat) tick();
      s_arready = 1; #1;
      checks++;
      if (((who != 0) ? m1_arready : m0_arready) !== 1'b1 ||
          ((who != 0) ? m0_arready : m1_arready) !== 1'b0) begin
         failures++;
         $display("FAIL rd_arready: m0_arready=%b m1_arready=%b owner=%0d", m0_arready, m1_arready, who);
      end
      tick();
      s_arready = 0;
      if (who != 0) m1_arvalid = 0; else m0_arvalid = 0;
      if (mid_lsu) begin
         m1_araddr = $urandom; m1_arvalid = 1;
      end
      for (int b = 0; b <= len; b++) begin
         lat = (rlat < 0) ? $urandom_range(0, 2) : rlat;
         repeat (lat) tick();
         d = fix_d ? fdata : $urandom;
         rsp = (fresp < 0) ? 2'($urandom_range(0, 3)) : 2'(fresp);
         s_rvalid = 1; s_rdata = d; s_rresp = rsp; s_rlast = (b == len); s_rid = eid; #1;
         checks++;
         if (((who != 0) ? m1_rvalid : m0_rvalid) !== 1'b1 ||
             ((who != 0) ? m1_rdata : m0_rdata) !== d ||
             ((who != 0) ? m1_rresp : m0_rresp) !== rsp ||
             ((who != 0) ? m1_rlast : m0_rlast) !== (b == len) ||
             ((who != 0) ? m1_rid : m0_rid) !== eid ||
             ((who != 0) ? m0_rvalid : m1_rvalid) !== 1'b0 ||
             s_rready !== 1'b1 || grant !== eg) begin
            failures++;
            $display("FAIL rd_beat%0d: owner=%0d m0 v=%b d=%h r=%b l=%b m1 v=%b d=%h r=%b l=%b rready=%b grant=%b expected d=%h r=%b",
                     b, who, m0_rvalid, m0_rdata, m0_rresp, m0_rlast, m1_rvalid, m1_rdata,
                     m1_rresp, m1_rlast, s_rready, grant, d, rsp);
         end
         if (mid_lsu) begin
            checks++;
            if (m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin
               failures++;
               $display("FAIL rd_block_lsu: m1_arready=%b s_arvalid=%b expected 0 0", m1_arready, s_arvalid);
            end
         end
         tick();
         s_rvalid = 0; s_rlast = 0;
      end
      #1;
      checks++;
      if (grant !== 2'b00) begin
         failures++; $display("FAIL rd_release: grant=%b expected=00", grant);
      end
      model_last = (who != 0) ? 1 : 0;
   endtask

   // order: 0 = W first, 1 = AW first, 2 = same cycle, <0 = random.
   task automatic serve_write(input int order_in);
      int order, lat;
      logic [1:0] rsp;
      logic [IW-1:0] eid;
      eid = m1_awid;
      order = (order_in < 0) ? $urandom_range(0, 2) : order_in;
      tick(); #1;
      checks++;
      if (grant !== 2'b10) begin
         failures++; $display("FAIL wr_grant: grant=%b expected=10", grant);
      end
      checks++;
      if (s_awvalid !== 1'b1 || s_awaddr !== m1_awaddr || s_awid !== eid || s_awlen !== m1_awlen ||
          s_wvalid !== 1'b1 || s_wdata !== m1_wdata || s_wstrb !== m1_wstrb || s_wlast !== m1_wlast ||
          s_arvalid !== 1'b0 || m0_arready !== 1'b0 || s_rready !== 1'b0) begin
         failures++;
         $display("FAIL wr_fwd: awv=%b awaddr=%h wv=%b wdata=%h wstrb=%b arv=%b expected awaddr=%h wdata=%h wstrb=%b",
                  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_arvalid, m1_awaddr, m1_wdata, m1_wstrb);
      end
      s_wready = (order != 1); s_awready = (order != 0); #1;
      checks++;
      if (m1_wready !== (order != 1) || m1_awready !== (order != 0)) begin
         failures++;
         $display("FAIL wr_ready1: wready=%b awready=%b order=%0d", m1_wready, m1_awready, order);
      end
      tick();
      s_wready = 0; s_awready = 0;
      if (order != 1) m1_wvalid = 0;
      if (order != 0) m1_awvalid = 0;
      if (order != 2) begin
         s_wready = (order == 1); s_awready = (order == 0); #1;
         checks++;
         if (m1_wready !== (order == 1) || m1_awready !== (order == 0)) begin
            failures++;
            $display("FAIL wr_ready2: wready=%b awready=%b order=%0d", m1_wready, m1_awready, order);
         end
         tick();
         s_wready = 0; s_awready = 0; m1_wvalid = 0; m1_awvalid = 0;
      end
      lat = $urandom_range(0, 2);
      repeat (lat) tick();
      rsp = 2'($urandom_range(0, 3));
      s_bvalid = 1; s_bresp = rsp; s_bid = eid; #1;
      checks++;
      if (m1_bvalid !== 1'b1 || m1_bresp !== rsp || m1_bid !== eid || s_bready !== 1'b1 ||
          grant !== 2'b10 || s_arvalid !== 1'b0) begin
         failures++;
         $display("FAIL wr_b: bvalid=%b bresp=%b bid=%h bready=%b grant=%b arvalid=%b expected bresp=%b bid=%h",
                  m1_bvalid, m1_bresp, m1_bid, s_bready, grant, s_arvalid, rsp, eid);
      end
      tick();
      s_bvalid = 0; #1;
      checks++;
      if (grant !== 2'b00) begin
         failures++; $display("FAIL wr_release: grant=%b expected=00", grant);
      end
      model_last = 1;
   endtask

   task automatic test_reset();
      init_inputs();
      reset = 0;
      m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1; s_rvalid = 1; s_bvalid = 1;
      s_rdata = 32'hA5A5_5A5A; s_rresp = 2'b11;
      repeat (2) tick();
      checks++;
      if (grant !== 2'b00) begin
         failures++; $display("FAIL reset_grant: grant=%b expected=00", grant);
      end
      checks++;
      if ({m0_arready, m1_arready, m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid,
           s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 12'b0) begin
         failures++; $display("FAIL reset_ctrl: some handshake output nonzero during reset");
      end
      checks++;
      if (m0_rdata !== '0 || m1_rdata !== '0 || s_araddr !== '0 || s_wdata !== '0 || m0_rresp !== 2'b00) begin
         failures++; $display("FAIL reset_data: m0_rdata=%h m1_rdata=%h s_araddr=%h expected 0", m0_rdata, m1_rdata, s_araddr);
      end
      init_inputs();
      tick();
      reset = 1;
      model_last = 1;
      tick();
   endtask

   task automatic test_ifu_read();
      m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_arlen = 8'd0; m0_arvalid = 1; #1;
      checks++;
      if (grant !== 2'b00 || s_arvalid !== 1'b0) begin
         failures++; $display("FAIL idle_no_valid: grant=%b s_arvalid=%b expected 00 0", grant, s_arvalid);
      end
      serve_read(0, 3, 1'b1, 32'h0000_0413, 0, 1'b0);
   endtask

   task automatic test_simultaneous();
      int first;
      m0_araddr = 32'h8000_0040; m0_arlen = 8'd0; m0_arvalid = 1;
      m1_araddr = 32'h8000_2000; m1_arlen = 8'd1; m1_arvalid = 1;
      first = pick_model(1'b1, 1'b1, 1'b0);
      serve_read(first, -1, 1'b0, '0, -1, 1'b0);
      serve_read((first != 0) ? 0 : 1, -1, 1'b0, '0, -1, 1'b0);
   endtask

   task automatic test_lsu_write();
      m1_awaddr = 32'h8000_1000; m1_awid = 4'h5; m1_awlen = 8'd0; m1_awvalid = 1;
      m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b1111; m1_wlast = 1; m1_wvalid = 1;
      serve_write(0);
      m0_arvalid = 1; m0_araddr = 32'h8000_0100; m0_arlen = 8'd0;
      m1_awaddr = 32'h8000_1004; m1_awvalid = 1; m1_wdata = 32'h1234_5678; m1_wvalid = 1;
      if (pick_model(1'b1, 1'b0, 1'b1) == 2) begin
         serve_write(-1);
         serve_read(0, -1, 1'b0, '0, -1, 1'b0);
      end else begin
         serve_read(0, -1, 1'b0, '0, -1, 1'b0);
         serve_write(-1);
      end
   endtask

   task automatic test_burst();
      m0_araddr = 32'h8000_0200; m0_arlen = 8'd3; m0_arid = 4'h1; m0_arvalid = 1;
      serve_read(0, -1, 1'b0, '0, -1, 1'b1);
      serve_read(1, -1, 1'b0, '0, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      m0_araddr = 32'h8000_0300; m0_arlen = 8'd0; m0_arvalid = 1;
      tick();
      s_arready = 1;
      tick();
      s_arready = 0; m0_arvalid = 0;
      s_rvalid = 1; s_rdata = 32'hCAFE_0001; s_rlast = 1; #1;
      checks++;
      if (m0_rvalid !== 1'b1 || grant !== 2'b01) begin
         failures++; $display("FAIL mid_pre: m0_rvalid=%b grant=%b expected 1 01", m0_rvalid, grant);
      end
      #1 reset = 0; #1;
      checks++;
      if (grant !== 2'b00 || {m0_arready, m1_arready, m1_awready, m1_wready, m0_rvalid, m1_rvalid,
          m1_bvalid, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 12'b0 || m0_rdata !== '0) begin
         failures++; $display("FAIL mid_reset: grant=%b m0_rvalid=%b s_rready=%b m0_rdata=%h expected all 0", grant, m0_rvalid, s_rready, m0_rdata);
      end
      tick();
      init_inputs();
      tick();
      reset = 1;
      model_last = 1;
      tick();
      m0_araddr = 32'h8000_0400; m0_arlen = 8'd1; m0_arvalid = 1;
      serve_read(0, -1, 1'b0, '0, -1, 1'b0);
   endtask

   task automatic test_resp_error();
      m1_araddr = 32'h8000_3000; m1_arlen = 8'd0; m1_arid = 4'h9; m1_arvalid = 1;
      serve_read(1, 1, 1'b0, '0, 2, 1'b0);
   endtask

   task automatic test_random();
      bit ar0, ar1, aw1;
      int w, mask;
      for (int t = 0; t < 12; t++) begin
         mask = $urandom_range(1, 7);
         ar0 = mask[0]; ar1 = mask[1]; aw1 = mask[2];
         m0_araddr = $urandom; m0_arid = 4'($urandom); m0_arlen = 8'($urandom_range(0, 3)); m0_arvalid = ar0;
         m1_araddr = $urandom; m1_arid = 4'($urandom); m1_arlen = 8'($urandom_range(0, 3)); m1_arvalid = ar1;
         m1_awaddr = $urandom; m1_awid = 4'($urandom); m1_awlen = 8'd0; m1_awvalid = aw1;
         m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_wlast = 1; m1_wvalid = aw1;
         while (ar0 || ar1 || aw1) begin
            w = pick_model(ar0, ar1, aw1);
            if (w == 0) begin
               serve_read(0, -1, 1'b0, '0, -1, 1'b0); ar0 = 0;
            end else if (w == 1) begin
               serve_read(1, -1, 1'b0, '0, -1, 1'b0); ar1 = 0;
            end else begin
               serve_write(-1); aw1 = 0;
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      model_last = 1;
      test_reset();
      test_ifu_read();
      test_simultaneous();
      test_lsu_write();
      test_burst();
      test_reset_mid();
      test_resp_error();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
